// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/result handshake bundle for the nibble-serial adder/subtractor.
// The master drives requests and consumes results; the slave is the datapath block.
interface nibble_serial_addsub_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-cycle A+B / A-B unit that processes one 4-bit slice per clock,
// LSB slice first, with a valid/ready request side and a held result side.
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    nibble_serial_addsub_ctrl_if.slave    bus
);
    localparam int DATA_W = 4 * NIBBLES;
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] a_l;
    logic [DATA_W-1:0] b_l;
    logic              sub_l;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic       accept;
    logic       consume;
    logic       last_slice;
    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [5:0] slice_res;

    // Returns {carry out of bit 3, carry into bit 3, 4-bit sum}; the carry into
    // the top bit is kept separately so the final slice can derive signed overflow.
    function automatic logic [5:0] slice_add(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [3:0] lo;
        logic [1:0] hi;
        lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
        hi = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, lo[3]};
        return {hi[1], lo[3], hi[0], lo[2:0]};
    endfunction

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE) && !rst;
    assign bus.busy      = (state_q != IDLE) && !rst;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign consume    = bus.out_valid && bus.out_ready;
    assign last_slice = (idx_q == LAST_IDX);

    // Subtraction is A + ~B + 1: the inversion happens per slice, the +1 is the
    // carry register preloaded with sub at acceptance.
    always_comb begin
        a_nib     = a_l[4*idx_q +: 4];
        b_nib     = b_l[4*idx_q +: 4] ^ {4{sub_l}};
        slice_res = slice_add(a_nib, b_nib, carry_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (consume)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_l     <= '0;
            b_l     <= '0;
            sub_l   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_l     <= bus.a;
                b_l     <= bus.b;
                sub_l   <= bus.sub;
                carry_q <= bus.sub;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                sum_q[4*idx_q +: 4] <= slice_res[3:0];
                carry_q             <= slice_res[5];
                if (last_slice) begin
                    cout_q <= slice_res[5];
                    ovf_q  <= slice_res[5] ^ slice_res[4];
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/nibble_serial_addsub_ctrl.md
NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand, so operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operation request is present.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-006 The block SHALL have port a, input, W, the first operand.
REQ-007 The block SHALL have port b, input, W, the second operand.
REQ-008 The block SHALL have port sub, input, 1, where 0 selects A+B and 1 selects A-B.
REQ-009 The block SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port sum, output, W, the result.
REQ-012 The block SHALL have port cout, output, 1, the carry out of the MSB slice; for a subtract, 1 means no borrow (A >= B unsigned).
REQ-013 The block SHALL have port ovf, output, 1, the two's-complement signed overflow.
REQ-014 The block SHALL have port busy, output, 1, asserted whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL implement three FSM states: IDLE, RUN and DONE.
REQ-016 The block SHALL drive in_ready = 1 only in IDLE with rst low; it is 0 in RUN and DONE.
REQ-017 Acceptance SHALL occur on a rising edge with in_valid && in_ready: latch a, b and sub; load carry register with sub; clear slice index to 0; go to RUN.
REQ-018 The block SHALL sample operands only at acceptance; input changes during RUN or DONE SHALL have no effect.
REQ-019 Each RUN cycle SHALL process slice i: nibble = A[i] + (B[i] XOR {4{sub_l}}) + carry, with the 4-bit result written to sum[4i+3:4i] and carry updated to that slice's carry out.
REQ-020 The slice index SHALL increment by 1 per RUN cycle; after slice NIBBLES-1 the FSM SHALL go to DONE, and the index SHALL NOT wrap or continue.
REQ-021 On the final slice, cout SHALL capture the slice carry out, and ovf SHALL capture (carry into bit W-1) XOR (carry out of bit W-1).
REQ-022 out_valid SHALL rise exactly NIBBLES cycles after the accepting edge and SHALL be 1 only in DONE.
REQ-023 In DONE, sum, cout and ovf SHALL hold stable while out_valid=1 && out_ready=0 (backpressure, unbounded).
REQ-024 On an edge with out_valid && out_ready, the FSM SHALL return to IDLE; a new request SHALL be accepted no earlier than the following edge, giving a minimum occupancy of NIBBLES+2 cycles per operation.
REQ-025 If out_ready is already 1 when out_valid rises, the result SHALL be consumed on the first DONE edge.
REQ-026 sum, cout and ovf SHALL be defined only while out_valid=1; after consumption they SHALL hold their last values until the next acceptance.
REQ-027 in_valid SHALL be ignored outside IDLE, with no queuing and no error indication.

Reset
REQ-028 On a rising edge with rst=1 the block SHALL enter IDLE and clear sum, cout, ovf, the carry register, the slice index and the latched operands to 0.
REQ-029 While rst=1, out_valid=0, busy=0 and in_ready=0; in_ready becomes 1 in the first cycle with rst low.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation, produce no out_valid, and discard the result.
REQ-031 rst SHALL have priority over every simultaneous handshake on the same edge.

Verification
REQ-032 The bench SHALL cover: NIBBLES=4, 0x1234 + 0x4321 -> sum=0x5555, cout=0, ovf=0, with out_valid exactly 4 cycles after acceptance.
REQ-033 The bench SHALL cover: 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0; and 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-034 The bench SHALL cover: 0x0003 - 0x0005 -> sum=0xFFFE, cout=0, ovf=0; and 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-035 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid and sum stable throughout; a single out_ready pulse -> IDLE on the next edge, in_ready=1.
REQ-036 The bench SHALL cover: operands changed and in_valid toggled during RUN -> result matches the originally latched operands; in_ready stays 0.
REQ-037 The bench SHALL cover: rst pulsed during the second RUN cycle -> no out_valid, outputs 0, busy=0; the next request completes correctly.
